// File: rtl/seg7_writer_if.sv
// Write-port bundle between the segment writer and its neighbours.
// The writer takes the master view. The requester and register-bank side take the slave view.
interface seg7_writer_if;
  logic        start;
  logic [23:0] value;
  logic        stall;
  logic [6:0]  data;
  logic [2:0]  addr;
  logic        sel;
  logic        busy;
  logic        done;

  modport master (
    input  start, value, stall,
    output data, addr, sel, busy, done
  );

  modport slave (
    output start, value, stall,
    input  data, addr, sel, busy, done
  );
endinterface

// File: rtl/seg7_writer.sv
// Captures a 24-bit hex value and writes six active-high segment patterns,
// one per cycle, to display registers 0..5. Leading-zero blanking is optional.
module seg7_writer #(
  parameter bit LZB = 1'b0
) (
  input logic           clk,
  input logic           rst,
  seg7_writer_if.master bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]  state_reg,  state_next;
  logic [23:0] shadow_reg, shadow_next;
  logic [2:0]  cnt_reg,    cnt_next;
  logic        done_reg,   done_next;

  logic [5:0]  nz;
  logic [6:0]  pat [0:7];
  logic        busy;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // A digit is blank when it and every digit above it are zero.
  // Digit 0 is never blanked, so a zero value still shows "0".
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      if (gi < 6) begin : g_real
        logic [3:0] nib;
        logic       blank;
        assign nib    = shadow_reg[4*gi +: 4];
        assign nz[gi] = |nib;
        if (gi == 0) begin : g_lsd
          assign blank = 1'b0;
        end else begin : g_upper
          assign blank = LZB && !(|nz[5:gi]);
        end
        assign pat[gi] = blank ? 7'h00 : hex2seg(nib);
      end else begin : g_pad
        assign pat[gi] = 7'h00;
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    cnt_next    = cnt_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shadow_next = bus.value;
          cnt_next    = 3'd0;
          state_next  = WRITE;
        end
      end
      default: begin
        if (!bus.stall) begin
          if (cnt_reg == 3'd5) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shadow_reg <= 24'h000000;
      cnt_reg    <= 3'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      cnt_reg    <= cnt_next;
      done_reg   <= done_next;
    end
  end

  // Stall gates the strobe combinationally so a held write never lands twice.
  assign busy     = (state_reg == WRITE);
  assign bus.busy = busy;
  assign bus.sel  = busy && !bus.stall;
  assign bus.addr = busy ? cnt_reg : 3'd0;
  assign bus.data = busy ? pat[cnt_reg] : 7'h00;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_seg7_writer.sv
// Drives an LZB=0 and an LZB=1 writer with identical stimulus.
// Each cycle it compares both against a queue-of-expected-writes reference.
module tb_seg7_writer;

  logic clk;
  logic rst;

  seg7_writer_if bus0 ();
  seg7_writer_if bus1 ();

  seg7_writer #(.LZB(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  seg7_writer #(.LZB(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                   'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  // Pending writes per instance, each entry is (addr << 8) | data.
  int q [2][$];
  bit done_exp [2];
  bit cur_stall;
  bit last_done;
  int rec [2][$];

  function automatic int exp_pat(int lzb, logic [23:0] v, int i);
    int h = 0;
    for (int j = 0; j < 6; j++)
      if (((v >> (4*j)) & 24'hF) != 0) h = j;
    if (lzb != 0 && i > h) return 0;
    return tbl[(v >> (4*i)) & 24'hF];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    logic [6:0] ed;
    logic [2:0] ea;
    logic       es, eb;
    int         e;
    for (int k = 0; k < 2; k++) begin
      if (q[k].size() > 0) begin
        e  = q[k][0];
        eb = 1'b1;
        ea = 3'((e >> 8) & 7);
        ed = 7'(e & 127);
        es = !cur_stall;
      end else begin
        eb = 1'b0; ea = 3'd0; ed = 7'd0; es = 1'b0;
      end
      chk($sformatf("data%0d", k), 32'(k == 0 ? bus0.data : bus1.data), 32'(ed));
      chk($sformatf("addr%0d", k), 32'(k == 0 ? bus0.addr : bus1.addr), 32'(ea));
      chk($sformatf("sel%0d",  k), 32'(k == 0 ? bus0.sel  : bus1.sel),  32'(es));
      chk($sformatf("busy%0d", k), 32'(k == 0 ? bus0.busy : bus1.busy), 32'(eb));
      chk($sformatf("done%0d", k), 32'(k == 0 ? bus0.done : bus1.done), 32'(done_exp[k]));
    end
  endtask

  task automatic model_edge(bit st, logic [23:0] v, bit sl);
    for (int k = 0; k < 2; k++) begin
      done_exp[k] = 1'b0;
      if (q[k].size() > 0) begin
        if (!sl) begin
          void'(q[k].pop_front());
          if (q[k].size() == 0) done_exp[k] = 1'b1;
        end
      end else if (st) begin
        for (int i = 0; i < 6; i++) q[k].push_back((i << 8) | exp_pat(k, v, i));
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      done_exp[k] = 1'b0;
    end
  endtask

  task automatic run_cycle(bit st, logic [23:0] v, bit sl);
    bus0.start = st; bus0.value = v; bus0.stall = sl;
    bus1.start = st; bus1.value = v; bus1.stall = sl;
    cur_stall = sl;
    #2;
    check_outputs();
    last_done = bus0.done;
    if (bus0.sel === 1'b1) rec[0].push_back((int'(bus0.addr) << 8) | int'(bus0.data));
    if (bus1.sel === 1'b1) rec[1].push_back((int'(bus1.addr) << 8) | int'(bus1.data));
    @(posedge clk);
    model_edge(st, v, sl);
    #1;
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    cur_stall = 1'b0;
    bus0.stall = 1'b0; bus1.stall = 1'b0;
    check_outputs();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_recorded(string tag, int k, int expd [6]);
    chk({tag, "_count"}, 32'(rec[k].size()), 32'd6);
    for (int i = 0; i < 6 && i < rec[k].size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(rec[k][i]), 32'((i << 8) | expd[i]));
  endtask

  initial begin
    int n;
    bit st, sl;
    logic [23:0] v;
    int basic_exp [6] = '{'h71, 'h3F, 'h7C, 'h77, 'h5B, 'h06};
    int lzb_exp   [6] = '{'h71, 'h66, 'h00, 'h00, 'h00, 'h00};
    int zero_exp  [6] = '{'h3F, 'h00, 'h00, 'h00, 'h00, 'h00};
    int ones_exp  [6] = '{'h71, 'h71, 'h71, 'h71, 'h71, 'h71};

    rst = 1'b1;
    bus0.start = 1'b0; bus0.value = '0; bus0.stall = 1'b0;
    bus1.start = 1'b0; bus1.value = '0; bus1.stall = 1'b0;
    cur_stall = 1'b0;
    model_reset();
    #3;
    check_outputs();
    #9 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 24'h0, 1'b0);

    // Basic sequence: Done in cycle 7.
    rec[0].delete(); rec[1].delete();
    run_cycle(1'b1, 24'h12AB0F, 1'b0);
    n = 0;
    do begin n++; run_cycle(1'b0, 24'h0, 1'b0); end while (!last_done && n < 40);
    chk("basic_done_cycle", 32'(n), 32'd7);
    check_recorded("basic", 0, basic_exp);

    // Blanking on the LZB=1 instance.
    rec[0].delete(); rec[1].delete();
    run_cycle(1'b1, 24'h00004F, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 24'h0, 1'b0);
    check_recorded("lzb4f", 1, lzb_exp);
    rec[0].delete(); rec[1].delete();
    run_cycle(1'b1, 24'h000000, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 24'h0, 1'b0);
    check_recorded("lzb0", 1, zero_exp);

    // Stall in cycles 3..4 gives Done in cycle 9. Also inject a start while busy.
    rec[0].delete(); rec[1].delete();
    run_cycle(1'b1, 24'h12AB0F, 1'b0);
    n = 0;
    do begin
      n++;
      run_cycle(n == 2, 24'h999999, (n == 3 || n == 4));
    end while (!last_done && n < 40);
    chk("stall_done_cycle", 32'(n), 32'd9);
    check_recorded("stall", 0, basic_exp);

    // Back-to-back: start accepted in the Done cycle.
    run_cycle(1'b1, 24'h000123, 1'b0);
    n = 0;
    while (!done_exp[0] && n < 40) begin n++; run_cycle(1'b0, 24'h0, 1'b0); end
    rec[0].delete(); rec[1].delete();
    run_cycle(1'b1, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 7; i++) run_cycle(1'b0, 24'h0, 1'b0);
    check_recorded("b2b", 0, ones_exp);

    // Reset after the Addr 2 write, then restart from Addr 0.
    run_cycle(1'b1, 24'h654321, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 24'h0, 1'b0);
    async_reset();
    run_cycle(1'b0, 24'h0, 1'b0);
    rec[0].delete(); rec[1].delete();
    run_cycle(1'b1, 24'h0000A0, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 24'h0, 1'b0);
    chk("restart_first_addr", 32'(rec[0].size() > 0 ? rec[0][0] >> 8 : 99), 32'd0);

    // Randomized traffic with varying leading-zero counts, stalls and resets.
    for (int c = 0; c < 1500; c++) begin
      st = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 3) == 0);
      v  = 24'($urandom >> (4 * $urandom_range(2, 8)));
      if ($urandom_range(0, 199) == 0) async_reset();
      else run_cycle(st, v, sl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
